// File: rtl/oe_sort_engine.sv
// ============================================================================
// oe_sort_engine
// ----------------------------------------------------------------------------
// Iterative odd-even transposition sorter. It accepts one vector of N W-bit
// elements on a valid/ready input. It then runs exactly N compare-and-swap
// phases, one per clock, and presents the sorted vector on a valid/ready
// output. Only one vector is in flight at a time.
//
// Ordering is ascending (element 0 smallest) or descending, selected by
// 'descend'. That input is sampled together with the vector. Comparison is
// unsigned or two's-complement, fixed at elaboration by SIGNED. Equal
// elements never swap, so the sort is stable.
//
// Parameters
//   N       number of elements (N >= 2)
//   W       element width in bits
//   SIGNED  1: two's-complement compare, 0: unsigned compare
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    producer has a vector on in_data
//   in_ready    engine is idle and will accept a vector
//   in_data     input vector, element i at [i*W +: W]
//   descend     0: ascending, 1: descending (captured on accept)
//   out_valid   sorted vector is available on out_data
//   out_ready   consumer takes the sorted vector
//   out_data    sorted vector, same packing as in_data
//   swap_count  total swaps performed for this vector (saturating)
//   busy        high while compare-and-swap phases are running
// ============================================================================
module oe_sort_engine #(
    parameter int N      = 6,
    parameter int W      = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [N*W-1:0]                    in_data,
    input  logic                              descend,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [N*W-1:0]                    out_data,
    output logic [$clog2(N*(N-1)/2+1)-1:0]    swap_count,
    output logic                              busy
);

    // Swap counter width covers the worst case of N*(N-1)/2 swaps
    // (a fully reversed vector).
    localparam int CW = $clog2(N*(N-1)/2+1);
    // The phase counter runs from 0 to N-1.
    localparam int PW = $clog2(N);
    localparam logic [PW-1:0] LAST_PHASE = PW'(N-1);
    // Saturation ceiling of the swap counter.
    localparam logic [CW:0]   CNT_MAX    = (CW+1)'((1 << CW) - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [W-1:0]   work      [N];
    logic [W-1:0]   next_work [N];
    logic [N*W-1:0] next_flat;
    logic           desc_q;
    logic [PW-1:0]  phase;
    logic [CW:0]    phase_swaps;
    logic [CW:0]    count_sum;
    logic [CW-1:0]  count_next;

    // The result is true when the pair (a, b) is in the wrong order for the
    // requested direction. A strict comparison keeps equal keys in place.
    function automatic logic out_of_order(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic         desc);
        logic gt;
        logic lt;
        if (SIGNED) begin
            gt = $signed(a) > $signed(b);
            lt = $signed(a) < $signed(b);
        end else begin
            gt = a > b;
            lt = a < b;
        end
        return desc ? lt : gt;
    endfunction

    // One compare-and-swap phase. Even phases pair (0,1),(2,3),... and odd
    // phases pair (1,2),(3,4),... . A pair starts at j when j has the same
    // parity as the phase. An unpaired end element falls outside every pair
    // and keeps its value.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            next_work[i] = work[i];
        end
        phase_swaps = '0;
        for (int j = 0; j < N-1; j++) begin
            if (j[0] == phase[0]) begin
                if (out_of_order(work[j], work[j+1], desc_q)) begin
                    next_work[j]   = work[j+1];
                    next_work[j+1] = work[j];
                    phase_swaps    = phase_swaps + (CW+1)'(1);
                end
            end
        end
    end

    // Flatten the post-phase vector so it can be loaded into out_data on the
    // final phase.
    always_comb begin
        next_flat = '0;
        for (int i = 0; i < N; i++) begin
            next_flat[i*W +: W] = next_work[i];
        end
    end

    // Add this phase's swaps to the running total, clamped at the counter's
    // maximum value.
    always_comb begin
        count_sum  = {1'b0, swap_count} + phase_swaps;
        count_next = (count_sum > CNT_MAX) ? CNT_MAX[CW-1:0] : count_sum[CW-1:0];
    end

    // Control FSM and datapath registers. IDLE accepts a vector. SORT runs
    // phases 0..N-1, one per edge, with no early exit, so latency never
    // depends on the data. DONE holds the result until the consumer takes
    // it. in_ready, busy and out_valid are registered and track the state
    // directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            out_data   <= '0;
            swap_count <= '0;
            phase      <= '0;
            desc_q     <= 1'b0;
            for (int i = 0; i < N; i++) begin
                work[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        for (int i = 0; i < N; i++) begin
                            work[i] <= in_data[i*W +: W];
                        end
                        desc_q     <= descend;
                        swap_count <= '0;
                        phase      <= '0;
                        in_ready   <= 1'b0;
                        busy       <= 1'b1;
                        state      <= SORT;
                    end
                end
                SORT: begin
                    for (int i = 0; i < N; i++) begin
                        work[i] <= next_work[i];
                    end
                    swap_count <= count_next;
                    if (phase == LAST_PHASE) begin
                        out_data  <= next_flat;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        phase     <= '0;
                        state     <= DONE;
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oe_sort_engine.sv
// ============================================================================
// tb_oe_sort_engine
// ----------------------------------------------------------------------------
// Self-checking bench for oe_sort_engine (N=6, W=8). It runs two instances
// side by side on shared stimulus: one with unsigned compare and one with
// signed compare. The reference model computes each expected result as a
// stable sort of the captured vector. It computes each expected swap count
// as the inversion count of that vector. Handshake timing is modelled as
// "valid N edges after accept".
// ============================================================================
module tb_oe_sort_engine;

    localparam int N  = 6;
    localparam int W  = 8;
    localparam int CW = $clog2(N*(N-1)/2+1);

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b1;
    logic           in_valid  = 1'b0;
    logic           descend   = 1'b0;
    logic           out_ready = 1'b0;
    logic [N*W-1:0] in_data   = '0;

    logic           in_ready_u, out_valid_u, busy_u;
    logic [N*W-1:0] out_data_u;
    logic [CW-1:0]  swap_count_u;
    logic           in_ready_s, out_valid_s, busy_s;
    logic [N*W-1:0] out_data_s;
    logic [CW-1:0]  swap_count_s;

    int checks = 0;
    int errors = 0;

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    oe_sort_engine #(.N(N), .W(W), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
        .in_data(in_data), .descend(descend), .out_valid(out_valid_u),
        .out_ready(out_ready), .out_data(out_data_u),
        .swap_count(swap_count_u), .busy(busy_u)
    );

    oe_sort_engine #(.N(N), .W(W), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .descend(descend), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_data(out_data_s),
        .swap_count(swap_count_s), .busy(busy_s)
    );

    // --------------------------------------------------------------------
    // Reference model helpers
    // --------------------------------------------------------------------
    function automatic logic [N*W-1:0] pack6(input logic [W-1:0] e0, input logic [W-1:0] e1,
                                             input logic [W-1:0] e2, input logic [W-1:0] e3,
                                             input logic [W-1:0] e4, input logic [W-1:0] e5);
        return {e5, e4, e3, e2, e1, e0};
    endfunction

    function automatic int key_of(input logic [W-1:0] v, input bit sgn);
        return sgn ? int'($signed(v)) : int'(v);
    endfunction

    // Stable insertion sort on the numeric key of each element.
    function automatic logic [N*W-1:0] model_sort(input logic [N*W-1:0] v, input bit desc,
                                                  input bit sgn);
        logic [W-1:0]   e [N];
        logic [W-1:0]   t;
        int             j;
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) e[i] = v[i*W +: W];
        for (int i = 1; i < N; i++) begin
            t = e[i];
            j = i - 1;
            while (j >= 0) begin
                if (desc ? (key_of(t, sgn) > key_of(e[j], sgn))
                         : (key_of(t, sgn) < key_of(e[j], sgn))) begin
                    e[j+1] = e[j];
                    j--;
                end else begin
                    break;
                end
            end
            e[j+1] = t;
        end
        r = '0;
        for (int i = 0; i < N; i++) r[i*W +: W] = e[i];
        return r;
    endfunction

    // Every adjacent swap removes exactly one inversion, so the total swap
    // count equals the inversion count, clamped at the counter maximum.
    function automatic int model_inv(input logic [N*W-1:0] v, input bit desc, input bit sgn);
        int cnt = 0;
        int a, b;
        for (int i = 0; i < N; i++) begin
            for (int k = i + 1; k < N; k++) begin
                a = key_of(v[i*W +: W], sgn);
                b = key_of(v[k*W +: W], sgn);
                if (desc ? (a < b) : (a > b)) cnt++;
            end
        end
        return (cnt > (1 << CW) - 1) ? (1 << CW) - 1 : cnt;
    endfunction

    // Generic comparison: counts the check and reports a mismatch.
    task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // --------------------------------------------------------------------
    // Behavioural timing/result model
    // --------------------------------------------------------------------
    typedef enum {M_IDLE, M_SORT, M_DONE} mstate_t;
    mstate_t        m_state = M_IDLE;
    int             m_cycles = 0;
    logic [N*W-1:0] m_exp_u = '0;
    logic [N*W-1:0] m_exp_s = '0;
    int             m_cnt_u = 0;
    int             m_cnt_s = 0;

    // Model update: capture expected results at accept, then count N edges
    // to the result, then wait for the consumer.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state  <= M_IDLE;
            m_cycles <= 0;
        end else begin
            case (m_state)
                M_IDLE: begin
                    if (in_valid) begin
                        m_exp_u  <= model_sort(in_data, descend, 1'b0);
                        m_exp_s  <= model_sort(in_data, descend, 1'b1);
                        m_cnt_u  <= model_inv(in_data, descend, 1'b0);
                        m_cnt_s  <= model_inv(in_data, descend, 1'b1);
                        m_cycles <= 0;
                        m_state  <= M_SORT;
                    end
                end
                M_SORT: begin
                    m_cycles <= m_cycles + 1;
                    if (m_cycles + 1 == N) m_state <= M_DONE;
                end
                M_DONE: begin
                    if (out_ready) m_state <= M_IDLE;
                end
                default: m_state <= M_IDLE;
            endcase
        end
    end

    // Compare process: on every falling edge out of reset, check both DUTs
    // against the model. Data and swap count are checked while valid.
    always @(negedge clk) begin
        if (rst_n) begin
            checkValue("in_ready_u",  in_ready_u,  m_state == M_IDLE);
            checkValue("busy_u",      busy_u,      m_state == M_SORT);
            checkValue("out_valid_u", out_valid_u, m_state == M_DONE);
            checkValue("in_ready_s",  in_ready_s,  m_state == M_IDLE);
            checkValue("busy_s",      busy_s,      m_state == M_SORT);
            checkValue("out_valid_s", out_valid_s, m_state == M_DONE);
            if (m_state == M_DONE) begin
                checkValue("out_data_u",   out_data_u,   m_exp_u);
                checkValue("out_data_s",   out_data_s,   m_exp_s);
                checkValue("swap_count_u", swap_count_u, 64'(m_cnt_u));
                checkValue("swap_count_s", swap_count_s, 64'(m_cnt_s));
            end
        end
    end

    // --------------------------------------------------------------------
    // Directed stimulus helpers
    // --------------------------------------------------------------------
    // Offer a vector once the engine is idle. After the accept edge, flip
    // descend and scramble in_data so that the captured values must be
    // used. Return the number of edges until out_valid.
    task automatic applyStimulus(input logic [N*W-1:0] vec, input logic desc, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready_u && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkValue("accept_ready", in_ready_u, 1'b1);
        in_data  = vec;
        descend  = desc;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        descend  = ~desc;
        in_data  = ~vec;
        lat = 0;
        while (!out_valid_u && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Check a finished vector against hand-computed literals.
    task automatic checkOutput(input string name, input int lat, input logic [N*W-1:0] exp_u,
                               input logic [N*W-1:0] exp_s, input int exp_cnt);
        checkValue({name, "_latency"}, 64'(lat), 64'(N));
        checkValue({name, "_valid"},   out_valid_u, 1'b1);
        checkValue({name, "_data_u"},  out_data_u, exp_u);
        checkValue({name, "_data_s"},  out_data_s, exp_s);
        checkValue({name, "_swaps_u"}, swap_count_u, 64'(exp_cnt));
    endtask

    task automatic releaseResult();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkValue("release_valid", out_valid_u, 1'b0);
        checkValue("release_ready", in_ready_u, 1'b1);
    endtask

    // --------------------------------------------------------------------
    // Main sequence
    // --------------------------------------------------------------------
    initial begin
        logic [N*W-1:0] v_mix, v_sorted, v_rev, v_dup, v_sgn;
        int lat;
        v_mix    = pack6(8'd5, 8'd3, 8'd9, 8'd1, 8'd7, 8'd2);
        v_sorted = pack6(8'd1, 8'd2, 8'd3, 8'd5, 8'd7, 8'd9);
        v_rev    = pack6(8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1);
        v_dup    = pack6(8'd4, 8'd4, 8'd2, 8'd2, 8'd4, 8'd2);
        v_sgn    = pack6(8'h80, 8'h7F, 8'h00, 8'hFF, 8'h01, 8'h81);

        // Pin the model itself with hand-computed results.
        checkValue("model_asc",  model_sort(v_mix, 1'b0, 1'b0), v_sorted);
        checkValue("model_desc", model_sort(v_mix, 1'b1, 1'b0),
                   pack6(8'd9, 8'd7, 8'd5, 8'd3, 8'd2, 8'd1));
        checkValue("model_sgn",  model_sort(v_sgn, 1'b0, 1'b1),
                   pack6(8'h80, 8'h81, 8'hFF, 8'h00, 8'h01, 8'h7F));
        checkValue("model_uns",  model_sort(v_sgn, 1'b0, 1'b0),
                   pack6(8'h00, 8'h01, 8'h7F, 8'h80, 8'h81, 8'hFF));
        checkValue("model_dup",  model_sort(v_dup, 1'b0, 1'b0),
                   pack6(8'd2, 8'd2, 8'd2, 8'd4, 8'd4, 8'd4));
        checkValue("model_inv_rev", 64'(model_inv(v_rev, 1'b0, 1'b0)), 64'd15);
        checkValue("model_inv_dup", 64'(model_inv(v_dup, 1'b0, 1'b0)), 64'd7);
        checkValue("model_inv_mix", 64'(model_inv(v_mix, 1'b0, 1'b0)), 64'd9);

        // Reset state.
        #1 rst_n = 1'b0;
        @(negedge clk);
        checkValue("rst_in_ready",  in_ready_u,   1'b1);
        checkValue("rst_out_valid", out_valid_u,  1'b0);
        checkValue("rst_busy",      busy_u,       1'b0);
        checkValue("rst_out_data",  out_data_u,   '0);
        checkValue("rst_swaps",     swap_count_u, '0);
        #2 rst_n = 1'b1;

        // Ascending sort of a mixed vector.
        applyStimulus(v_mix, 1'b0, lat);
        checkOutput("asc", lat, v_sorted, v_sorted, 9);
        releaseResult();

        // Reset asserted mid-sort clears everything at once.
        applyStimulus(v_mix, 1'b1, lat);
        checkOutput("desc", lat, pack6(8'd9, 8'd7, 8'd5, 8'd3, 8'd2, 8'd1),
                    pack6(8'd9, 8'd7, 8'd5, 8'd3, 8'd2, 8'd1), 6);
        releaseResult();
        @(negedge clk);
        in_data = v_rev; descend = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkValue("midrst_out_valid", out_valid_u,  1'b0);
        checkValue("midrst_in_ready",  in_ready_u,   1'b1);
        checkValue("midrst_busy",      busy_u,       1'b0);
        checkValue("midrst_out_data",  out_data_u,   '0);
        checkValue("midrst_swaps",     swap_count_u, '0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Sorted input needs no swaps; the latency stays the same.
        applyStimulus(v_sorted, 1'b0, lat);
        checkOutput("sorted", lat, v_sorted, v_sorted, 0);
        releaseResult();

        // Signed vs unsigned ordering.
        applyStimulus(v_sgn, 1'b0, lat);
        checkOutput("signed", lat, pack6(8'h00, 8'h01, 8'h7F, 8'h80, 8'h81, 8'hFF),
                    pack6(8'h80, 8'h81, 8'hFF, 8'h00, 8'h01, 8'h7F), 7);
        releaseResult();

        // Reverse input, then backpressure with a new vector waiting.
        applyStimulus(v_rev, 1'b0, lat);
        checkOutput("reverse", lat, pack6(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6),
                    pack6(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6), 15);
        in_data = v_dup; descend = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkValue("bp_data",  out_data_u,  pack6(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6));
            checkValue("bp_valid", out_valid_u, 1'b1);
            checkValue("bp_ready", in_ready_u,  1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkValue("bp_release_valid", out_valid_u, 1'b0);
        checkValue("bp_release_ready", in_ready_u,  1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid_u && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("dup", lat, pack6(8'd2, 8'd2, 8'd2, 8'd4, 8'd4, 8'd4),
                    pack6(8'd2, 8'd2, 8'd2, 8'd4, 8'd4, 8'd4), 7);
        releaseResult();

        // Randomised traffic: random valid/ready, data and direction every
        // cycle. Half of the vectors use a narrow range to create duplicates.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i < N; i++) in_data[i*W +: W] = W'($urandom_range(0, 3));
            end else begin
                for (int i = 0; i < N; i++) in_data[i*W +: W] = W'($urandom_range(0, 255));
            end
            descend   = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (N + 4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
